// File: rtl/bitwise_logic_unit.sv
// bitwise_logic_unit
//   Multi-cycle bitwise logic engine. Latches two WIDTH-bit operands and a 3-bit function code
//   on an in_valid/in_ready handshake, then evaluates SLICE result bits per cycle. The finished
//   result is offered on an out_valid/out_ready handshake.
//
//   Optional feature: define BITWISE_ZERO_FLAG_EN to add the registered `zero` output
//   (1 when the finished result is all zeros, valid with out_valid).
//
// Parameters
//   WIDTH      operand/result width, multiple of SLICE
//   SLICE      bits evaluated per cycle, >= 1, divides WIDTH
// Ports
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   operands and op present
//   in_ready   unit can accept (IDLE)
//   op         000 NOT A, 001 AND, 010 OR, 011 XOR, 100 NOR, 101 NAND, 110 XNOR, 111 PASS A
//   data_a     operand A
//   data_b     operand B (ignored for NOT/PASS)
//   out_valid  result valid (DONE)
//   out_ready  consumer takes result
//   result     registered result
//   busy       high in RUN or DONE
//   zero       (BITWISE_ZERO_FLAG_EN only) result == 0, valid with out_valid
module bitwise_logic_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
`ifdef BITWISE_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int unsigned N    = WIDTH / SLICE;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SLICE-1:0] a_slice, b_slice, f_slice;

  function automatic logic [SLICE-1:0] eval_slice(input logic [2:0]       fn,
                                                   input logic [SLICE-1:0] a,
                                                   input logic [SLICE-1:0] b);
    logic [SLICE-1:0] r;
    unique case (fn)
      3'b000:  r = ~a;
      3'b001:  r = a & b;
      3'b010:  r = a | b;
      3'b011:  r = a ^ b;
      3'b100:  r = ~(a | b);
      3'b101:  r = ~(a & b);
      3'b110:  r = ~(a ^ b);
      default: r = a;
    endcase
    return r;
  endfunction

  // Current slice of the latched operands, selected by the slice counter.
  always_comb begin
    a_slice = a_q[int'(idx_q) * SLICE +: SLICE];
    b_slice = b_q[int'(idx_q) * SLICE +: SLICE];
    f_slice = eval_slice(op_q, a_slice, b_slice);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d     = op;
          a_d      = data_a;
          b_d      = data_b;
          idx_d    = '0;
          result_d = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        result_d[int'(idx_q) * SLICE +: SLICE] = f_slice;
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

`ifdef BITWISE_ZERO_FLAG_EN
  // Running AND of per-slice zero tests; seeded to 1 on accept, frozen outside RUN.
  logic zero_q, zero_d;

  always_comb begin
    zero_d = zero_q;
    if (state_q == StIdle && in_valid) begin
      zero_d = 1'b1;
    end else if (state_q == StRun) begin
      zero_d = zero_q & (f_slice == '0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;
`endif

  // in_ready is gated by reset_n so it reads 0 while reset is held.
  assign in_ready  = (state_q == StIdle) & reset_n;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StRun) | (state_q == StDone);
  assign result    = result_q;

endmodule
